sequence_generator: RTL and testbench

SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

---
 rtl/sequence_generator.sv | 130 +++++++++++++
 tb/tb_sequence_generator.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sequence_generator.sv
// sequence_generator: serialises the top len bits of pattern MSB-first, one bit per clock.
// Ports:
//   clk        - single clock, all state on the rising edge
//   reset_n    - synchronous active-low reset
//   start      - transmit request, sampled only while idle
//   pattern    - bit pattern, sent from bit len-1 down to bit 0
//   len        - number of bits to send (0..MAX_LEN, larger values clamp to MAX_LEN)
//   reps       - extra passes of the captured pattern (only with SEQ_GEN_REPEAT_EN)
//   dout       - registered serial bit, 0 whenever dout_valid is low
//   dout_valid - registered, high on each cycle dout carries a pattern bit
//   busy       - registered, high from the accepted start until the last bit
//   done       - registered one-cycle pulse after each completed transfer
// Optional feature macro: SEQ_GEN_REPEAT_EN (adds reps and the repeat counter).
module sequence_generator #(
   parameter int MAX_LEN = 8,
   parameter int LW = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LW-1:0]      len,
`ifdef SEQ_GEN_REPEAT_EN
   input  logic [3:0]         reps,
`endif
   output logic               dout,
   output logic               dout_valid,
   output logic               busy,
   output logic               done
);
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
   state_t state, state_d;
   logic [MAX_LEN-1:0] sreg_q, sreg_d, aligned;
   logic [LW-1:0]      cnt_q, cnt_d, len_c;
   logic               dout_d, valid_d, busy_d, done_d;
`ifdef SEQ_GEN_REPEAT_EN
   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [LW-1:0]      len_q, len_d;
   logic [3:0]         rep_q, rep_d;
`endif
   assign len_c = (len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len;
   // Left-justify the pattern so the first bit to send is always the MSB of the shifter.
   assign aligned = pattern << (LW'(MAX_LEN) - len_c);
   always_comb begin
      state_d = state;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      dout_d  = 1'b0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
`ifdef SEQ_GEN_REPEAT_EN
      pat_d   = pat_q;
      len_d   = len_q;
      rep_d   = rep_q;
`endif
      case (state)
         IDLE: begin
            if (start && len_c == '0) begin
               done_d = 1'b1;
            end else if (start) begin
               state_d = SHIFT;
               sreg_d  = aligned;
               cnt_d   = len_c - 1'b1;
               dout_d  = aligned[MAX_LEN-1];
               valid_d = 1'b1;
               busy_d  = 1'b1;
`ifdef SEQ_GEN_REPEAT_EN
               pat_d   = aligned;
               len_d   = len_c;
               rep_d   = reps;
`endif
            end
         end
         SHIFT: begin
            // cnt_q counts bits still to send after the one currently on dout.
            if (cnt_q != '0) begin
               sreg_d  = sreg_q << 1;
               cnt_d   = cnt_q - 1'b1;
               dout_d  = sreg_q[MAX_LEN-2];
               valid_d = 1'b1;
               busy_d  = 1'b1;
`ifdef SEQ_GEN_REPEAT_EN
            end else if (rep_q != '0) begin
               // Restart from the captured copy so the next pass follows with no gap.
               rep_d   = rep_q - 1'b1;
               sreg_d  = pat_q;
               cnt_d   = len_q - 1'b1;
               dout_d  = pat_q[MAX_LEN-1];
               valid_d = 1'b1;
               busy_d  = 1'b1;
`endif
            end else begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         sreg_q     <= '0;
         cnt_q      <= '0;
         dout       <= 1'b0;
         dout_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
`ifdef SEQ_GEN_REPEAT_EN
         pat_q      <= '0;
         len_q      <= '0;
         rep_q      <= '0;
`endif
      end else begin
         state      <= state_d;
         sreg_q     <= sreg_d;
         cnt_q      <= cnt_d;
         dout       <= dout_d;
         dout_valid <= valid_d;
         busy       <= busy_d;
         done       <= done_d;
`ifdef SEQ_GEN_REPEAT_EN
         pat_q      <= pat_d;
         len_q      <= len_d;
         rep_q      <= rep_d;
`endif
      end
   end
endmodule

// File: tb/tb_sequence_generator.sv
// tb_sequence_generator: directed and random checks of sequence_generator against a queue-based model.
module tb_sequence_generator;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] pattern = '0;
   logic [3:0] len = '0;
   logic [3:0] reps = '0;
   logic       dout, dout_valid, busy, done;
   int         tests = 0;
   int         fails = 0;
   int         done_seen = 0;
   bit         chk_en = 1'b0;
   logic       m_dout = 1'b0, m_valid = 1'b0, m_busy = 1'b0, m_done = 1'b0;
   bit         pend[$];

   sequence_generator #(.MAX_LEN(8)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .start(start),
      .pattern(pattern),
      .len(len),
`ifdef SEQ_GEN_REPEAT_EN
      .reps(reps),
`endif
      .dout(dout),
      .dout_valid(dout_valid),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   // Model: a transfer is a queue of bits; one bit is shown per cycle, then a done cycle.
   always @(posedge clk) begin
      automatic logic nd = 1'b0, nv = 1'b0, nb = 1'b0, nn = 1'b0;
      automatic int n, passes;
      if (!reset_n) begin
         pend.delete();
      end else if (m_busy) begin
         if (pend.size() > 0) begin
            nd = pend.pop_front();
            nv = 1'b1;
            nb = 1'b1;
         end else begin
            nn = 1'b1;
         end
      end else if (start) begin
         n = (len > 8) ? 8 : int'(len);
`ifdef SEQ_GEN_REPEAT_EN
         passes = int'(reps) + 1;
`else
         passes = 1;
`endif
         if (n == 0) begin
            nn = 1'b1;
         end else begin
            for (int r = 0; r < passes; r++)
               for (int i = n - 1; i >= 0; i--) pend.push_back(pattern[i]);
            nd = pend.pop_front();
            nv = 1'b1;
            nb = 1'b1;
         end
      end
      m_dout  <= nd;
      m_valid <= nv;
      m_busy  <= nb;
      m_done  <= nn;
   end

   always @(negedge clk) begin
      if (done) done_seen++;
      if (chk_en) begin
         tests++;
         if ({dout, dout_valid, busy, done} !== {m_dout, m_valid, m_busy, m_done}) begin
            fails++;
            $display("FAIL model_cmp t=%0t dut{dout,valid,busy,done}=%b model=%b", $time,
                     {dout, dout_valid, busy, done}, {m_dout, m_valid, m_busy, m_done});
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   // Steps n cycles collecting dout; after the first cycle applies hold/np/nl to start/pattern/len.
   task automatic run_bits(input int n, input bit hold, input logic [7:0] np, input logic [3:0] nl,
                           output logic [15:0] got, output int vc);
      got = '0;
      vc = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (i == 0) begin
            start = hold;
            pattern = np;
            len = nl;
         end
         got = {got[14:0], dout & dout_valid};
         if (dout_valid && busy && !done) vc++;
      end
   endtask

   initial begin
      logic [15:0] got;
      int vc, d0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      chk("reset_outputs", {28'd0, dout, dout_valid, busy, done}, 32'd0);
      // Basic 4-bit transfer straight out of reset.
      reset_n = 1'b1;
      start = 1'b1;
      pattern = 8'b0000_1011;
      len = 4'd4;
      run_bits(4, 1'b0, 8'b0000_1011, 4'd4, got, vc);
      chk("t1_bits", {28'd0, got[3:0]}, 32'hB);
      chk("t1_valid_cnt", vc, 4);
      @(negedge clk);
      chk("t1_done_cycle", {29'd0, dout_valid, busy, done}, 32'b001);
      // Start during done: back-to-back A5.
      start = 1'b1;
      pattern = 8'hA5;
      len = 4'd8;
      run_bits(8, 1'b0, 8'hA5, 4'd8, got, vc);
      chk("t2_bits", {24'd0, got[7:0]}, 32'hA5);
      chk("t2_valid_cnt", vc, 8);
      @(negedge clk);
      chk("t2_done", {31'd0, done}, 32'd1);
      // len = 0: done only.
      start = 1'b1;
      len = 4'd0;
      @(negedge clk);
      start = 1'b0;
      chk("t3_len0", {29'd0, dout_valid, busy, done}, 32'b001);
      @(negedge clk);
      chk("t3_done_drop", {29'd0, dout_valid, busy, done}, 32'b000);
      // Reset on the 2nd bit of an 8-bit transfer, start held during reset.
      start = 1'b1;
      pattern = 8'hFF;
      len = 4'd8;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("t4_second_bit", {30'd0, dout_valid, busy}, 32'b11);
      reset_n = 1'b0;
      start = 1'b1;
      @(negedge clk);
      chk("t4_reset_mid", {28'd0, dout, dout_valid, busy, done}, 32'd0);
      @(negedge clk);
      chk("t4_reset_start", {28'd0, dout, dout_valid, busy, done}, 32'd0);
      reset_n = 1'b1;
      start = 1'b0;
      @(negedge clk);
      chk("t4_after_reset", {28'd0, dout, dout_valid, busy, done}, 32'd0);
      // Start held high, pattern/len changed mid-transfer.
      d0 = done_seen;
      start = 1'b1;
      pattern = 8'hCA;
      len = 4'd8;
      run_bits(8, 1'b1, 8'h05, 4'd3, got, vc);
      chk("t5_bits", {24'd0, got[7:0]}, 32'hCA);
      chk("t5_valid_cnt", vc, 8);
      @(negedge clk);
      chk("t5_done", {31'd0, done}, 32'd1);
      run_bits(3, 1'b0, 8'h05, 4'd3, got, vc);
      chk("t5_second_bits", {29'd0, got[2:0]}, 32'b101);
      @(negedge clk);
      @(negedge clk);
      chk("t5_done_count", done_seen - d0, 2);
`ifdef SEQ_GEN_REPEAT_EN
      // Three passes of 1011.
      reps = 4'd2;
      start = 1'b1;
      pattern = 8'h0B;
      len = 4'd4;
      run_bits(12, 1'b0, 8'h0B, 4'd4, got, vc);
      chk("t6_bits", {20'd0, got[11:0]}, 32'hBBB);
      chk("t6_valid_cnt", vc, 12);
      @(negedge clk);
      chk("t6_done", {30'd0, busy, done}, 32'b01);
      reps = 4'd0;
`endif
      // Random phase; the model compare checks every cycle.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 3) == 0);
         pattern = 8'($urandom);
         len = 4'($urandom_range(0, 15));
         reps = 4'($urandom_range(0, 3));
         reset_n = ($urandom_range(0, 199) != 0);
      end
      reset_n = 1'b1;
      start = 1'b0;
      repeat (60) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
